locker_ctrl: RTL and testbench

LOCKER_CTRL -- requirements
Module: locker_ctrl

---
 rtl/locker_pkg.sv | 21 ++
 rtl/locker_fail_ctr.sv | 22 ++
 rtl/locker_ctrl.sv | 136 +++++++++++++
 tb/tb_locker_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/locker_pkg.sv
// Shared types and default password table for the locker controller.
package locker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CHECK   = 2'd1,
    ST_GRANT   = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

  localparam logic [11:0] DEFAULT_TABLE [4] = '{12'hf2a, 12'h0aa, 12'hece, 12'h999};

  // Slot u takes table[u%4]; the result is zero-extended, then masked to pass_w bits.
  function automatic logic [31:0] default_pass(input int u, input int pass_w);
    logic [31:0] v;
    v = {20'd0, DEFAULT_TABLE[2'(u % 4)]};
    if (pass_w < 32) v = v & ((32'd1 << pass_w) - 32'd1);
    return v;
  endfunction

endpackage

// File: rtl/locker_fail_ctr.sv
// Per-user saturating failure counter with synchronous clear.
module locker_fail_ctr #(
  parameter int MAX_TRIES = 3
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] cnt
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= 4'd0;
    end else if (clr) begin
      cnt <= 4'd0;
    end else if (inc && (cnt < 4'(MAX_TRIES))) begin
      cnt <= cnt + 4'd1;
    end
  end

endmodule

// File: rtl/locker_ctrl.sv
// Multi-user password locker with per-user lockout.
// Define LOCKER_PROG_EN to allow reprogramming a slot's password during a grant.
module locker_ctrl
  import locker_pkg::*;
#(
  parameter int NUM_USERS     = 4,
  parameter int PASS_W        = 12,
  parameter int MAX_TRIES     = 3,
  parameter int ACCESS_CYCLES = 8,
  parameter int LOCK_CYCLES   = 16,
  localparam int UW           = $clog2(NUM_USERS)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enter,
  input  logic [UW-1:0]     user,
  input  logic [PASS_W-1:0] pass_in,
  input  logic              prog,
  input  logic [PASS_W-1:0] new_pass,
  output logic              access,
  output logic              alarm,
  output logic              deny,
  output logic              busy,
  output logic [3:0]        fail_cnt
);

  localparam int MAXC = (ACCESS_CYCLES > LOCK_CYCLES) ? ACCESS_CYCLES : LOCK_CYCLES;
  localparam int TW   = $clog2(MAXC + 1);

  state_t              state, state_nx;
  logic [UW-1:0]       user_q;
  logic [PASS_W-1:0]   pass_q;
  logic [TW-1:0]       timer;
  logic                deny_q, deny_d;
  logic [PASS_W-1:0]   slot [NUM_USERS];
  logic [3:0]          cnt  [NUM_USERS];
  logic [NUM_USERS-1:0] inc, clr;
  logic                user_ok, match, at_limit;

  assign user_ok  = (int'(user_q) < NUM_USERS);
  assign match    = user_ok && (pass_q == slot[user_q]);
  assign at_limit = user_ok && (cnt[user_q] >= 4'(MAX_TRIES - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= ST_IDLE;
      user_q <= '0;
      pass_q <= '0;
      deny_q <= 1'b0;
    end else begin
      state  <= state_nx;
      deny_q <= deny_d;
      if (state == ST_IDLE && enter) begin
        user_q <= user;
        pass_q <= pass_in;
      end
    end
  end

  always_comb begin
    state_nx = state;
    inc      = '0;
    clr      = '0;
    deny_d   = 1'b0;
    case (state)
      ST_IDLE: if (enter) state_nx = ST_CHECK;
      ST_CHECK: begin
        if (!user_ok) begin
          deny_d   = 1'b1;
          state_nx = ST_IDLE;
        end else if (match) begin
          clr[user_q] = 1'b1;
          state_nx    = ST_GRANT;
        end else begin
          inc[user_q] = 1'b1;
          deny_d      = 1'b1;
          state_nx    = at_limit ? ST_LOCKOUT : ST_IDLE;
        end
      end
      ST_GRANT: if (enter || timer == '0) state_nx = ST_IDLE;
      ST_LOCKOUT: begin
        if (timer == '0) begin
          if (user_ok) clr[user_q] = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Timer is loaded on entry so that GRANT/LOCKOUT last exactly N cycles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      timer <= '0;
    end else if (state_nx == ST_GRANT && state != ST_GRANT) begin
      timer <= TW'(ACCESS_CYCLES - 1);
    end else if (state_nx == ST_LOCKOUT && state != ST_LOCKOUT) begin
      timer <= TW'(LOCK_CYCLES - 1);
    end else if (timer != '0) begin
      timer <= timer - TW'(1);
    end
  end

`ifdef LOCKER_PROG_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_USERS; i++) slot[i] <= PASS_W'(default_pass(i, PASS_W));
    end else if (state == ST_GRANT && enter && prog && user_ok) begin
      slot[user_q] <= new_pass;
    end
  end
`else
  always_comb begin
    for (int i = 0; i < NUM_USERS; i++) slot[i] = PASS_W'(default_pass(i, PASS_W));
  end
  logic unused_prog;
  assign unused_prog = ^{prog, new_pass};
`endif

  for (genvar g = 0; g < NUM_USERS; g++) begin : g_ctr
    locker_fail_ctr #(.MAX_TRIES(MAX_TRIES)) u_ctr (
      .clk  (clk),
      .rstn (rstn),
      .inc  (inc[g]),
      .clr  (clr[g]),
      .cnt  (cnt[g])
    );
  end

  assign access   = (state == ST_GRANT);
  assign alarm    = (state == ST_LOCKOUT);
  assign busy     = (state != ST_IDLE);
  assign deny     = deny_q;
  assign fail_cnt = user_ok ? cnt[user_q] : 4'd0;

endmodule

// File: tb/tb_locker_ctrl.sv
// Directed vector bench for locker_ctrl (default parameters).
module tb_locker_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enter = 1'b0;
  logic [1:0]  user = '0;
  logic [11:0] pass_in = '0;
  logic        prog = 1'b0;
  logic [11:0] new_pass = '0;
  logic        access, alarm, deny, busy;
  logic [3:0]  fail_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        en;
    logic [1:0]  u;
    logic [11:0] p;
    logic        acc, al, dn, bs;
    logic [3:0]  fc;
  } vec_t;

  vec_t vecs[$];

  locker_ctrl dut (
    .clk      (clk),
    .rstn     (rstn),
    .enter    (enter),
    .user     (user),
    .pass_in  (pass_in),
    .prog     (prog),
    .new_pass (new_pass),
    .access   (access),
    .alarm    (alarm),
    .deny     (deny),
    .busy     (busy),
    .fail_cnt (fail_cnt)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic en, input logic [1:0] u, input logic [11:0] p,
                              input logic acc, input logic al, input logic dn,
                              input logic bs, input logic [3:0] fc);
    vec_t v;
    v.en = en; v.u = u; v.p = p;
    v.acc = acc; v.al = al; v.dn = dn; v.bs = bs; v.fc = fc;
    vecs.push_back(v);
  endfunction

  task automatic step(input logic en, input logic [1:0] u, input logic [11:0] p,
                      input logic pg, input logic [11:0] np);
    enter = en; user = u; pass_in = p; prog = pg; new_pass = np;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic acc, input logic al,
                       input logic dn, input logic bs, input logic [3:0] fc);
    checks++;
    if ({access, alarm, deny, busy, fail_cnt} !== {acc, al, dn, bs, fc}) begin
      errors++;
      $display("FAIL %s: got acc=%b alarm=%b deny=%b busy=%b fail_cnt=%0d, expected acc=%b alarm=%b deny=%b busy=%b fail_cnt=%0d",
               name, access, alarm, deny, busy, fail_cnt, acc, al, dn, bs, fc);
    end
  endtask

  initial begin
    // Grant for user 0: CHECK, then exactly 8 access cycles, then IDLE.
    add(1, 0, 12'hf2a, 0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) add(0, 0, 12'h000, 1, 0, 0, 1, 0);
    add(0, 0, 12'h000, 0, 0, 0, 0, 0);
    // User 1: three failures, enter ignored in CHECK and LOCKOUT, 16-cycle lockout.
    add(1, 1, 12'h000, 0, 0, 0, 1, 0);
    add(0, 1, 12'h000, 0, 0, 1, 0, 1);
    add(1, 1, 12'h000, 0, 0, 0, 1, 1);
    add(1, 0, 12'hf2a, 0, 0, 1, 0, 2);
    add(1, 1, 12'h000, 0, 0, 0, 1, 2);
    add(0, 1, 12'h000, 0, 1, 1, 1, 3);
    for (int i = 0; i < 15; i++) add(1, 0, 12'hf2a, 0, 1, 0, 1, 3);
    add(0, 0, 12'h000, 0, 0, 0, 0, 0);
    // User 2 fails twice, user 3 granted, early end, user 2 still at 2.
    add(1, 2, 12'h000, 0, 0, 0, 1, 0);
    add(0, 2, 12'h000, 0, 0, 1, 0, 1);
    add(1, 2, 12'h000, 0, 0, 0, 1, 1);
    add(0, 2, 12'h000, 0, 0, 1, 0, 2);
    add(1, 3, 12'h999, 0, 0, 0, 1, 0);
    add(0, 3, 12'h000, 1, 0, 0, 1, 0);
    add(1, 3, 12'h000, 0, 0, 0, 0, 0);
    add(1, 2, 12'hece, 0, 0, 0, 1, 2);
    add(0, 2, 12'h000, 1, 0, 0, 1, 0);
    add(1, 2, 12'h000, 0, 0, 0, 0, 0);

    // Clock/reset
    #1;
    check("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rstn = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].u, vecs[i].p, 1'b0, 12'h000);
      check($sformatf("vec[%0d]", i), vecs[i].acc, vecs[i].al, vecs[i].dn, vecs[i].bs, vecs[i].fc);
    end

    // Program attempt during grant of user 0.
    step(1, 0, 12'hf2a, 0, 12'h000); check("prog_check", 0, 0, 0, 1, 0);
    step(0, 0, 12'h000, 0, 12'h000); check("prog_grant", 1, 0, 0, 1, 0);
    step(1, 0, 12'h000, 1, 12'h123); check("prog_exit", 0, 0, 0, 0, 0);
`ifdef LOCKER_PROG_EN
    step(1, 0, 12'hf2a, 0, 12'h000); check("old_check", 0, 0, 0, 1, 0);
    step(0, 0, 12'h000, 0, 12'h000); check("old_denied", 0, 0, 1, 0, 1);
    step(1, 0, 12'h123, 0, 12'h000); check("new_check", 0, 0, 0, 1, 1);
    step(0, 0, 12'h000, 0, 12'h000); check("new_grant", 1, 0, 0, 1, 0);
    step(1, 0, 12'h000, 0, 12'h000); check("new_exit", 0, 0, 0, 0, 0);
    rstn = 1'b0;
    #1;
    rstn = 1'b1;
    step(1, 0, 12'hf2a, 0, 12'h000); check("restored_check", 0, 0, 0, 1, 0);
    step(0, 0, 12'h000, 0, 12'h000); check("restored_grant", 1, 0, 0, 1, 0);
`else
    step(1, 0, 12'h123, 0, 12'h000); check("new_check", 0, 0, 0, 1, 0);
    step(0, 0, 12'h000, 0, 12'h000); check("new_denied", 0, 0, 1, 0, 1);
    step(1, 0, 12'hf2a, 0, 12'h000); check("old_check", 0, 0, 0, 1, 1);
    step(0, 0, 12'h000, 0, 12'h000); check("old_grant", 1, 0, 0, 1, 0);
`endif

    // Asynchronous reset in the middle of a grant.
    step(0, 0, 12'h000, 0, 12'h000); check("grant_held", 1, 0, 0, 1, 0);
    #2;
    rstn = 1'b0;
    #1;
    check("rst_mid_grant", 0, 0, 0, 0, 0);
    @(negedge clk);
    rstn = 1'b1;

    // Asynchronous reset in the middle of a lockout.
    for (int k = 1; k <= 3; k++) begin
      step(1, 1, 12'h000, 0, 12'h000);
      step(0, 1, 12'h000, 0, 12'h000);
    end
    check("lock_entry", 0, 1, 1, 1, 3);
    step(0, 1, 12'h000, 0, 12'h000);
    step(0, 1, 12'h000, 0, 12'h000); check("lock_held", 0, 1, 0, 1, 3);
    #2;
    rstn = 1'b0;
    #1;
    check("rst_mid_lock", 0, 0, 0, 0, 0);
    @(negedge clk);
    rstn = 1'b1;
    step(1, 1, 12'h000, 0, 12'h000); check("count_cleared", 0, 0, 0, 1, 0);
    step(0, 1, 12'h000, 0, 12'h000); check("fail_after_rst", 0, 0, 1, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
